// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed N-digit 7-segment display scanner
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_code, disp_code;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, zero_from;
  logic                    pend_valid, slot_end, frame_end, blank;
  logic [3:0]              cur_code;
  logic [6:0]              glyph_on;
  function automatic logic [6:0] glyph(input logic [3:0] c, input logic hex);
    case (c)
      4'd0:    glyph = 7'h7E;
      4'd1:    glyph = 7'h30;
      4'd2:    glyph = 7'h6D;
      4'd3:    glyph = 7'h79;
      4'd4:    glyph = 7'h33;
      4'd5:    glyph = 7'h5B;
      4'd6:    glyph = 7'h5F;
      4'd7:    glyph = 7'h70;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h7B;
      4'd10:   glyph = hex ? 7'h77 : 7'h01;
      4'd11:   glyph = hex ? 7'h1F : 7'h01;
      4'd12:   glyph = hex ? 7'h4E : 7'h01;
      4'd13:   glyph = hex ? 7'h3D : 7'h01;
      4'd14:   glyph = hex ? 7'h4F : 7'h01;
      default: glyph = hex ? 7'h47 : 7'h01;
    endcase
  endfunction
  assign slot_end  = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign cur_code  = disp_code[4*idx +: 4];
  // zero_from[k] is set when digit k and every higher digit hold code 0
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = disp_code[4*NUM_DIGITS-1 -: 4] == 4'd0;
    for (int k = NUM_DIGITS - 2; k >= 0; k--)
      zero_from[k] = disp_code[4*k +: 4] == 4'd0 && zero_from[k+1];
  end
  // glyph of the digit currently being scanned, with leading-zero blanking
  always_comb begin
    blank    = blank_lz && idx != '0 && zero_from[idx];
    glyph_on = blank ? 7'h00 : glyph(cur_code, hex_en);
  end
  // slot counter and digit index; the last slot of the last digit ends a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
    end
  end
  // double buffer: display copies pending only on a frame boundary, load may land on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_code  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_code  <= '0;
      disp_dp    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end && pend_valid;
      if (frame_end && pend_valid) begin
        disp_code <= pend_code;
        disp_dp   <= pend_dp;
      end
      if (load) begin
        pend_code  <= bcd_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end
  // registered pin drivers; digit enables stay idle during the guard interval of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= {7{SEG_ACTIVE_LOW}};
      dp       <= SEG_ACTIVE_LOW;
      digit_en <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg      <= glyph_on ^ {7{SEG_ACTIVE_LOW}};
      dp       <= disp_dp[idx] ^ SEG_ACTIVE_LOW;
      digit_en <= (cnt < CW'(GUARD) ? '0 : NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks of two driver configurations against a frame-level model
module tb_seg7_scan_driver;
  localparam int N = 4, S = 8, G = 2, F = N * S;
  localparam logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load = 1'b0, hex_en = 1'b0, blank_lz = 1'b0, load2 = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dpi = '0, bcd2 = '0;
  logic [0:0]  dpi2 = '0;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, fd, fd2;
  logic [3:0]  de;
  logic [0:0]  de2;
  int          errors = 0, checks = 0, e = 0, fd_seen = 0, fd2_seen = 0;
  logic [3:0]  m_code [N], p_code [N];
  logic [3:0]  m_dp, p_dp, m2_code, p2_code;
  logic        m2_dp, p2_dp;
  bit          pv, pv2;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .GUARD(G), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd), .dp_in(dpi), .hex_en(hex_en), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .digit_en(de), .frame_done(fd));

  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(2), .GUARD(0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .bcd_in(bcd2), .dp_in(dpi2), .hex_en(hex_en), .blank_lz(blank_lz),
    .seg(seg2), .dp(dp2), .digit_en(de2), .frame_done(fd2));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] c, input logic h);
    return (c > 4'd9 && !h) ? 7'h01 : GLY[c];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    e = 0; pv = 0; pv2 = 0; m_dp = '0; p_dp = '0;
    m2_code = '0; p2_code = '0; m2_dp = 0; p2_dp = 0;
    for (int j = 0; j < N; j++) begin m_code[j] = '0; p_code[j] = '0; end
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, dp, 1);
    chk({tag, "_de"}, de, 4'hF);
    chk({tag, "_fd"}, fd, 0);
    chk({tag, "_seg2"}, seg2, 7'h00);
    chk({tag, "_de2"}, de2, 0);
    chk({tag, "_fd2"}, fd2, 0);
  endtask

  // one clock: predict pins from the pre-edge frame position, advance the model, then compare
  task automatic step();
    int s, c;
    bit blank, xfd, xfd2;
    logic [6:0] xs, xs2;
    logic [3:0] oh, xde;
    logic xdp, xdp2;
    s = (e / S) % N;
    c = e % S;
    blank = blank_lz && s != 0;
    for (int j = s; j < N; j++) if (m_code[j] != 4'd0) blank = 0;
    xs  = ~(blank ? 7'h00 : ref_glyph(m_code[s], hex_en));
    xdp = ~m_dp[s];
    oh  = 4'b0001 << s;
    xde = c < G ? 4'hF : ~oh;
    xfd = (e % F == F - 1) && pv;
    if (xfd) begin m_code = p_code; m_dp = p_dp; pv = 0; end
    if (load) begin
      for (int j = 0; j < N; j++) p_code[j] = bcd[4*j +: 4];
      p_dp = dpi; pv = 1;
    end
    xs2  = ref_glyph(m2_code, hex_en);
    xdp2 = m2_dp;
    xfd2 = (e % 2 == 1) && pv2;
    if (xfd2) begin m2_code = p2_code; m2_dp = p2_dp; pv2 = 0; end
    if (load2) begin p2_code = bcd2; p2_dp = dpi2[0]; pv2 = 1; end
    e++;
    @(posedge clk);
    #1;
    chk("seg", seg, xs);
    chk("dp", dp, xdp);
    chk("digit_en", de, xde);
    chk("frame_done", fd, xfd);
    chk("seg2", seg2, xs2);
    chk("dp2", dp2, xdp2);
    chk("digit_en2", de2, 1);
    chk("frame_done2", fd2, xfd2);
    if (fd) fd_seen++;
    if (fd2) fd2_seen++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < F && (e % F) != target; k++) step();
    chk("run_to", e % F, target);
  endtask

  // asynchronous reset in the middle of a low clock phase
  task automatic areset();
    #2 rst_n = 1'b0;
    #1 chk_reset_pins("async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    chk_reset_pins("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step();
    run_to(10);
    bcd = 16'h1234; dpi = 4'b0100; load = 1'b1;
    step();
    load = 1'b0; fd_seen = 0;
    run_to(3); step();
    chk("d1234_slot0", seg, 7'h4C);
    chk("d1234_fd_count", fd_seen, 1);
    run_to(19); step();
    chk("d1234_slot2", seg, 7'h12);
    chk("d1234_slot2_dp", dp, 0);
    bcd = 16'h00A7; dpi = 4'b0000; hex_en = 1'b1; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    run_to(10); step();
    chk("hexA", seg, 7'h08);
    hex_en = 1'b0;
    step();
    chk("dash", seg, 7'h7E);
    hex_en = 1'b1;
    run_to(18); step();
    chk("blank_slot2", seg, 7'h7F);
    run_to(26); step();
    chk("blank_slot3", seg, 7'h7F);
    run_to(2); step();
    chk("slot0_7", seg, 7'h0F);
    bcd = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    run_to(0); run_to(2); step();
    chk("all_zero_slot0", seg, 7'h01);
    run_to(10); step();
    chk("all_zero_slot1", seg, 7'h7F);
    blank_lz = 1'b0;
    bcd = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    run_to(31);
    fd_seen = 0;
    bcd = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    run_to(4); step();
    chk("bnd_1111", seg, 7'h4F);
    run_to(4); step();
    chk("bnd_2222", seg, 7'h12);
    chk("bnd_fd_count", fd_seen, 2);
    bcd = 16'h5555; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    areset();
    fd_seen = 0;
    for (int i = 0; i < 2 * F; i++) step();
    chk("rst_fd_count", fd_seen, 0);
    bcd2 = 4'd5; dpi2 = 1'b1; load2 = 1'b1;
    step();
    load2 = 1'b0; fd2_seen = 0;
    for (int i = 0; i < 4; i++) step();
    chk("d2_fd_count", fd2_seen, 1);
    chk("d2_seg", seg2, 7'h5B);
    chk("d2_dp", dp2, 1);
    for (int i = 0; i < 2500; i++) begin
      load  = $urandom_range(0, 19) == 0;
      bcd   = 16'($urandom);
      dpi   = 4'($urandom);
      load2 = $urandom_range(0, 3) == 0;
      bcd2  = 4'($urandom);
      dpi2  = 1'($urandom);
      if ($urandom_range(0, 39) == 0) hex_en = ~hex_en;
      if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 2) == 0) bcd[15:8] = 8'h00;
      if ($urandom_range(0, 499) == 0) areset();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode/common-cathode 7-segment display. Accepts packed 4-bit digit codes with decimal points, double-buffers them so updates land only on frame boundaries, and scans one digit per slot. Optional leading-zero blanking, hex or BCD-with-error glyphs, and anti-ghosting guard interval per slot. Sits between the datapath's result registers and the board display pins.

## Interface
- NUM_DIGITS, 4, digit count; legal 1..8
- SCAN_DIV, 1000, clock cycles per digit slot; legal ≥ 2
- GUARD, 2, cycles at slot start with all digit enables inactive; legal 0..SCAN_DIV-1
- SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low
- DIG_ACTIVE_LOW, 1, 1 = digit_en pins active-low

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  capture bcd_in/dp_in into pending buffer this cycle
- bcd_in  in  4*NUM_DIGITS  digit codes; digit 0 = bits [3:0] (least significant)
- dp_in  in  NUM_DIGITS  decimal point per digit
- hex_en  in  1  1 = codes 10–15 show A,b,C,d,E,F; 0 = show dash (G only)
- blank_lz  in  1  1 = blank leading zeros
- seg  out  7  segments, seg[6]=A … seg[0]=G
- dp  out  1  decimal point of current digit
- digit_en  out  NUM_DIGITS  one-hot digit enable (or all off)
- frame_done  out  1  one-cycle pulse when display buffer is updated

## Operation
- Registers: pending buffer (codes+dp), pend_valid flag, display buffer, slot counter cnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1).
- cnt increments every cycle; at SCAN_DIV-1 wraps to 0 and idx increments; idx wraps NUM_DIGITS-1→0 (frame boundary).
- load=1: pending ← {bcd_in, dp_in}, pend_valid ← 1.
- Frame boundary with pend_valid=1: display ← pending, pend_valid ← 0, frame_done pulses next cycle. Boundary with pend_valid=0: no transfer, no pulse.
- Simultaneous load and boundary: display takes pending contents from before this edge (if pend_valid was 1); pending takes new data and pend_valid stays 1 for the next boundary.
- Glyphs (active-high, A..G): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B; hex_en=1: A=77 b=1F C=4E d=3D E=4F F=47; hex_en=0: codes 10–15 = 01.
- Leading-zero blank (blank_lz=1): digit k blanked (seg all off, dp unchanged) if display codes of k and all higher digits are 0; digit 0 never blanked. hex_en/blank_lz sampled live, not buffered.
- Polarity: seg/dp inverted when SEG_ACTIVE_LOW=1; digit_en inverted when DIG_ACTIVE_LOW=1. "Off"/"inactive" below means the polarity-correct idle level.

## Timing
- Outputs seg, dp, digit_en registered: value in cycle t+1 reflects idx, cnt, display buffer at cycle t.
- Slot k: digit_en inactive while cnt < GUARD, then only bit k active for SCAN_DIV-GUARD cycles; seg/dp show digit k for the whole slot.
- Frame = NUM_DIGITS*SCAN_DIV cycles; load-to-display latency ≤ one frame + 1 cycle.
- Reset (async assert, sync release): cnt=0, idx=0, pending=0, pend_valid=0, display=0, seg/dp off, digit_en all inactive, frame_done=0. Reset mid-frame discards pending data.
- NUM_DIGITS=1: every slot wrap is a frame boundary.

## Test plan
- Reset, defaults, no load: after reset seg=7'h7F (all off, active-low), digit_en=4'hF; scanning then shows "0000" (seg=7'h01 each slot), digit_en cycles E,D,B,7 with 2 cycles F at each slot start.
- load bcd_in=16'h1234, dp_in=4'b0100 mid-frame: display unchanged until boundary, frame_done pulses once, then slot 0 shows 4 (active-high 33), slot 2 shows 2 with dp on.
- bcd_in=16'h00A7, hex_en toggled: slot 1 shows A (77) when hex_en=1, dash (01) when 0; blank_lz=1 blanks slots 2,3 only; bcd_in=0 with blank_lz=1 shows single 0 on slot 0.
- Load asserted exactly on boundary cycle after earlier load of 16'h1111 then 16'h2222: display=1111 this frame, 2222 next frame, two frame_done pulses.
- Assert rst_n=0 mid-slot with pending data: outputs off immediately (asynchronous), after release display shows 0000, no frame_done.
- NUM_DIGITS=1, SCAN_DIV=2, GUARD=0, both polarities active-high: digit_en constantly 1, frame_done one cycle after first boundary following load.
